ct_mem_arbiter: RTL and testbench
=================================

Name: ct_mem_arbiter

Overview:
- Round-robin arbiter sharing the single-port ciphertext memory among N_CORES parallel crack cores, each searching its own key subset.
- Sits between the cores' ct_addr/ct_rddata interfaces and the one ciphertext memory port of the multi-core cracker top level.
- Replaces ad-hoc address muxing with an explicit req/gnt handshake and tags each read return to the requester that issued it.

Parameters:
- N_CORES, 4, number of requesting crack cores (2..8).
- RD_LAT, 1, ciphertext memory read latency in cycles (1..3).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_CORES  per-core read request; held high until granted.
- req_addr  input  8*N_CORES  per-core ciphertext address; core i uses bits [8i+7:8i].
- gnt  output  N_CORES  one-hot grant, combinational in the request cycle.
- rvalid  output  N_CORES  one-hot: read data for core i is on rddata this cycle.
- rddata  output  8  ciphertext byte broadcast to all cores.
- flush  input  1  global stop (key found or run aborted); cancels all in-flight reads.
- busy  output  1  high while any read is in flight.
- mem_addr  output  8  address to the ciphertext memory.
- mem_rddata  input  8  memory read data, valid RD_LAT cycles after mem_addr.

Behaviour:
- Reset (rst high, async):
  - Priority pointer = 0.
  - rvalid pipeline cleared.
  - gnt = 0, rvalid = 0, busy = 0, mem_addr = 0.
- Arbitration: each cycle, at most one grant.
  - Search starts at the priority pointer and proceeds upward modulo N_CORES; the first core with req=1 is granted.
  - gnt is asserted in the same cycle req is seen, with no added latency.
- Pointer update: after a grant to core i, the pointer becomes (i+1) mod N_CORES on the next edge. With no grant, the pointer holds.
- Fairness: a continuously asserted req is granted within N_CORES cycles.
- mem_addr:
  - Equals req_addr of the granted core in the grant cycle.
  - When there is no grant, mem_addr holds its last value; memory reads while idle are harmless.
- Return path:
  - Shift register of RD_LAT one-hot entries; stage 0 is loaded with gnt.
  - rvalid = final stage.
  - rddata = mem_rddata, passed straight through with no register.
  - Exactly one rvalid per grant, RD_LAT cycles after it.
- Back-to-back: a new grant is allowed every cycle. The same core may receive consecutive grants only when it is the sole requester.
- Core handshake: a core drops req or changes req_addr only in the cycle after it sees gnt. A req deasserted before grant is simply not serviced.
- flush:
  - While flush=1, gnt is forced to 0, all pipeline stages clear on the next edge, and rvalid is forced to 0 combinationally.
  - The pointer resets to 0 on the next edge.
  - Requests pending during flush are not queued. Cores re-request after flush is low.
- busy = OR of all pipeline stages; it is 0 in the cycle after a flush.
- Simultaneous flush and req: flush wins; no grant and no later rvalid.
- rst mid-operation: in-flight reads are discarded and no rvalid is produced for them.

Decomposition:
- Package ct_arb_pkg:
  - ct_addr_t (logic [7:0]).
  - CT_DATA_W = 8.
  - Defaults N_CORES_DEF = 4, RD_LAT_DEF = 1.
- Sub-module rr_pick:
  - Purely combinational rotate / priority-encode / unrotate.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and granted index.
  - Reused by any future arbiter in the cracker.
- The top contains the pointer register, the address mux, the rvalid pipeline and the flush logic.

Test Plan:
- Reset then idle: hold rst 3 cycles, release, all req=0 → gnt=0, rvalid=0, busy=0, mem_addr=0 for 10 cycles.
- Single requester: core 2 req with addr 8'h05, memory returns 8'hA7 → gnt=4'b0100 same cycle, mem_addr=8'h05, rvalid=4'b0100 with rddata=8'hA7 exactly RD_LAT cycles later.
- All four cores request continuously with addrs 1..4 → grant sequence 0,1,2,3,0,…, one grant per cycle; each core granted every 4 cycles; rvalid tags match grant order delayed by RD_LAT.
- Pointer wrap: only cores 3 and 0 request, pointer at 3 → grants 3,0,3,0; neither core waits more than one cycle.
- Flush in flight: grant core 1, assert flush the next cycle with core 0 requesting → no rvalid for core 1, no gnt to core 0 while flush is high, busy=0 after; the first grant after flush follows from pointer 0.
- Reset mid-read (RD_LAT=2): assert rst one cycle after a grant → rvalid never asserts for that grant; outputs at reset values.

Source files
------------

// File: rtl/ct_arb_pkg.sv
// Shared types and defaults for the ciphertext memory arbiter of the multi-core cracker.
package ct_arb_pkg;

    typedef logic [7:0] ct_addr_t;

    localparam int CT_DATA_W   = 8;
    localparam int N_CORES_DEF = 4;
    localparam int RD_LAT_DEF  = 1;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int c;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        // Walk the rotated request vector; the first hit is unrotated back to a core index.
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (!valid_o && req_i[c]) begin
                valid_o  = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/ct_mem_arbiter.sv
// Round-robin arbiter for the single-port ciphertext memory, with tagged read returns and flush.
module ct_mem_arbiter
    import ct_arb_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int RD_LAT  = RD_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CORES-1:0]   req,
    input  logic [8*N_CORES-1:0] req_addr,
    output logic [N_CORES-1:0]   gnt,
    output logic [N_CORES-1:0]   rvalid,
    output logic [CT_DATA_W-1:0] rddata,
    input  logic                 flush,
    output logic                 busy,
    output logic [7:0]           mem_addr,
    input  logic [CT_DATA_W-1:0] mem_rddata
);

    localparam int IW = $clog2(N_CORES);

    logic [IW-1:0]                   ptr_q, ptr_d;
    ct_addr_t                        addr_q, addr_d;
    logic [RD_LAT-1:0][N_CORES-1:0]  pipe_q, pipe_d;

    logic [N_CORES-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_vld;
    logic               grant_ok;

    rr_pick #(.N(N_CORES), .IW(IW)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    // Grant is also suppressed while rst is high so outputs sit at reset values.
    assign grant_ok = pick_vld & ~flush & ~rst;

    always_comb begin
        gnt    = grant_ok ? pick_gnt : '0;
        ptr_d  = ptr_q;
        addr_d = addr_q;
        if (flush) begin
            ptr_d = '0;
        end else if (grant_ok) begin
            ptr_d = IW'(wrap_inc(int'(pick_idx), N_CORES));
            for (int i = 0; i < N_CORES; i++) begin
                if (pick_gnt[i]) begin
                    addr_d = req_addr[8*i +: 8];
                end
            end
        end
        mem_addr = addr_d;
    end

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = gnt;
        for (int s = 1; s < RD_LAT; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
        if (flush) begin
            pipe_d = '0;
        end
    end

    assign rvalid = flush ? '0 : pipe_q[RD_LAT-1];
    assign busy   = |pipe_q;
    assign rddata = mem_rddata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            addr_q <= '0;
            pipe_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            addr_q <= addr_d;
            pipe_q <= pipe_d;
        end
    end

endmodule

// File: tb/tb_ct_mem_arbiter.sv
// Bench for ct_mem_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_ct_mem_arbiter;

    localparam int N      = 4;
    localparam int RD_LAT = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_addr;
    logic [N-1:0]   gnt, rvalid;
    logic [7:0]     rddata;
    logic           flush;
    logic           busy;
    logic [7:0]     mem_addr;
    logic [7:0]     mem_rddata;

    ct_mem_arbiter #(.N_CORES(N), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rddata     (rddata),
        .flush      (flush),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_rddata (mem_rddata)
    );

    always #5 clk = ~clk;

    // Memory model: data for an address appears RD_LAT cycles after it is presented.
    logic [7:0] mem [256];
    logic [7:0] addr_hist [RD_LAT];
    always @(posedge clk) begin
        addr_hist[0] <= mem_addr;
        for (int i = 1; i < RD_LAT; i++) addr_hist[i] <= addr_hist[i-1];
    end
    assign mem_rddata = mem[addr_hist[RD_LAT-1]];

    // Reference model: pointer, last address and a list of outstanding reads.
    typedef struct {
        int         core;
        int         rem;
        logic [7:0] addr;
    } pend_t;

    pend_t      pend [$];
    int         m_ptr;
    logic [7:0] m_last;
    int         e_g;
    logic [N-1:0] e_gnt, e_rv;
    logic [7:0] e_addr, e_data;
    logic       e_busy;

    int checks = 0;
    int errors = 0;

    task automatic eval_model();
        bit found;
        @(negedge clk);
        if (rst) begin
            pend.delete();
            m_ptr  = 0;
            m_last = '0;
        end
        e_g   = -1;
        found = 0;
        if (!rst && !flush) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && req[c]) begin
                    found = 1;
                    e_g   = c;
                end
            end
        end
        e_gnt = '0;
        if (e_g >= 0) e_gnt[e_g] = 1'b1;
        e_addr = (e_g >= 0) ? req_addr[8*e_g +: 8] : m_last;
        e_rv   = '0;
        e_data = '0;
        e_busy = (pend.size() != 0);
        foreach (pend[i]) begin
            if (pend[i].rem == 1 && !flush) begin
                e_rv[pend[i].core] = 1'b1;
                e_data = mem[pend[i].addr];
            end
        end
    endtask

    task automatic advance();
        pend_t nq [$];
        @(posedge clk);
        if (rst) begin
            pend.delete();
            m_ptr  = 0;
            m_last = '0;
        end else if (flush) begin
            pend.delete();
            m_ptr = 0;
        end else begin
            foreach (pend[i]) begin
                pend[i].rem = pend[i].rem - 1;
                if (pend[i].rem > 0) nq.push_back(pend[i]);
            end
            pend = nq;
            if (e_g >= 0) begin
                pend.push_back('{core: e_g, rem: RD_LAT, addr: e_addr});
                m_ptr  = (e_g + 1) % N;
                m_last = e_addr;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 13; i++) begin
            rst = (i < 3);
            req = '0;
            eval_model();
            if (gnt !== e_gnt)     begin errors++; $display("FAIL reset gnt got %b want %b", gnt, e_gnt); end
            if (rvalid !== e_rv)   begin errors++; $display("FAIL reset rvalid got %b want %b", rvalid, e_rv); end
            if (busy !== e_busy)   begin errors++; $display("FAIL reset busy got %b want %b", busy, e_busy); end
            if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset mem_addr got %h want 00", mem_addr); end
            checks += 4;
            advance();
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < RD_LAT + 3; i++) begin
            req = (i == 0) ? 4'b0100 : 4'b0000;
            req_addr[8*2 +: 8] = 8'h05;
            eval_model();
            if (i == 0) begin
                checks += 2;
                if (gnt !== 4'b0100) begin errors++; $display("FAIL single gnt got %b want 0100", gnt); end
                if (mem_addr !== 8'h05) begin errors++; $display("FAIL single mem_addr got %h want 05", mem_addr); end
            end
            if (i == RD_LAT) begin
                checks += 2;
                if (rvalid !== 4'b0100) begin errors++; $display("FAIL single rvalid got %b want 0100", rvalid); end
                if (rddata !== 8'hA7) begin errors++; $display("FAIL single rddata got %h want a7", rddata); end
            end
            if (gnt !== e_gnt)      begin errors++; $display("FAIL single gnt got %b want %b", gnt, e_gnt); end
            if (rvalid !== e_rv)    begin errors++; $display("FAIL single rvalid got %b want %b", rvalid, e_rv); end
            if (busy !== e_busy)    begin errors++; $display("FAIL single busy got %b want %b", busy, e_busy); end
            if (mem_addr !== e_addr) begin errors++; $display("FAIL single mem_addr got %h want %h", mem_addr, e_addr); end
            checks += 4;
            advance();
        end
    endtask

    task automatic test_all_req();
        int wait_cnt [N];
        for (int c = 0; c < N; c++) begin
            wait_cnt[c] = 0;
            req_addr[8*c +: 8] = 8'(c + 1);
        end
        for (int i = 0; i < 12 + RD_LAT + 1; i++) begin
            req = (i < 12) ? 4'hF : 4'h0;
            eval_model();
            for (int c = 0; c < N; c++) begin
                if (gnt[c]) begin
                    checks++;
                    if (wait_cnt[c] > N - 1) begin
                        errors++; $display("FAIL all_req wait core %0d got %0d want <= %0d", c, wait_cnt[c], N - 1);
                    end
                    wait_cnt[c] = 0;
                end else if (req[c]) begin
                    wait_cnt[c]++;
                end
            end
            if (gnt !== e_gnt)      begin errors++; $display("FAIL all_req gnt got %b want %b", gnt, e_gnt); end
            if (rvalid !== e_rv)    begin errors++; $display("FAIL all_req rvalid got %b want %b", rvalid, e_rv); end
            if (busy !== e_busy)    begin errors++; $display("FAIL all_req busy got %b want %b", busy, e_busy); end
            if (mem_addr !== e_addr) begin errors++; $display("FAIL all_req mem_addr got %h want %h", mem_addr, e_addr); end
            checks += 4;
            if (e_rv != '0) begin
                checks++;
                if (rddata !== e_data) begin errors++; $display("FAIL all_req rddata got %h want %h", rddata, e_data); end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9 + RD_LAT + 1; i++) begin
            if (i == 0)      req = 4'b0100;
            else if (i <= 8) req = 4'b1001;
            else             req = 4'b0000;
            eval_model();
            if (i >= 1 && i <= 8) begin
                checks++;
                if (gnt !== ((i % 2 == 1) ? 4'b1000 : 4'b0001)) begin
                    errors++; $display("FAIL wrap gnt cycle %0d got %b want %b", i, gnt, (i % 2 == 1) ? 4'b1000 : 4'b0001);
                end
            end
            if (gnt !== e_gnt)      begin errors++; $display("FAIL wrap gnt got %b want %b", gnt, e_gnt); end
            if (rvalid !== e_rv)    begin errors++; $display("FAIL wrap rvalid got %b want %b", rvalid, e_rv); end
            if (busy !== e_busy)    begin errors++; $display("FAIL wrap busy got %b want %b", busy, e_busy); end
            if (mem_addr !== e_addr) begin errors++; $display("FAIL wrap mem_addr got %h want %h", mem_addr, e_addr); end
            checks += 4;
            advance();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) begin
            flush = (i == 1);
            case (i)
                0:       req = 4'b0010;
                1:       req = 4'b0001;
                2:       req = 4'b1001;
                3:       req = 4'b1000;
                default: req = 4'b0000;
            endcase
            eval_model();
            if (i == 1) begin
                checks++;
                if (gnt !== 4'b0000) begin errors++; $display("FAIL flush gnt_during got %b want 0000", gnt); end
            end
            if (i == 2) begin
                checks += 3;
                if (gnt !== 4'b0001)  begin errors++; $display("FAIL flush gnt_after got %b want 0001", gnt); end
                if (busy !== 1'b0)    begin errors++; $display("FAIL flush busy_after got %b want 0", busy); end
                if (rvalid !== 4'b0000) begin errors++; $display("FAIL flush rvalid_cancel got %b want 0000", rvalid); end
            end
            if (gnt !== e_gnt)      begin errors++; $display("FAIL flush gnt got %b want %b", gnt, e_gnt); end
            if (rvalid !== e_rv)    begin errors++; $display("FAIL flush rvalid got %b want %b", rvalid, e_rv); end
            if (busy !== e_busy)    begin errors++; $display("FAIL flush busy got %b want %b", busy, e_busy); end
            if (mem_addr !== e_addr) begin errors++; $display("FAIL flush mem_addr got %h want %h", mem_addr, e_addr); end
            checks += 4;
            advance();
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_addr[8*2 +: 8] = 8'h33;
        for (int i = 0; i < 7; i++) begin
            req = (i == 0) ? 4'b0100 : 4'b0000;
            rst = (i == 1);
            eval_model();
            if (i >= 1) begin
                checks++;
                if (rvalid !== 4'b0000) begin errors++; $display("FAIL rst_mid rvalid cycle %0d got %b want 0000", i, rvalid); end
            end
            if (gnt !== e_gnt)      begin errors++; $display("FAIL rst_mid gnt got %b want %b", gnt, e_gnt); end
            if (rvalid !== e_rv)    begin errors++; $display("FAIL rst_mid rvalid got %b want %b", rvalid, e_rv); end
            if (busy !== e_busy)    begin errors++; $display("FAIL rst_mid busy got %b want %b", busy, e_busy); end
            if (mem_addr !== e_addr) begin errors++; $display("FAIL rst_mid mem_addr got %h want %h", mem_addr, e_addr); end
            checks += 4;
            rst = 1'b0;
            advance();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] seen_gnt;
        seen_gnt = '0;
        req      = '0;
        for (int i = 0; i < 400 + RD_LAT + 2; i++) begin
            if (i < 400) begin
                flush = ($urandom_range(0, 19) == 0);
                for (int c = 0; c < N; c++) begin
                    if (seen_gnt[c] || !req[c]) begin
                        req[c] = ($urandom_range(0, 2) == 0);
                        req_addr[8*c +: 8] = 8'($urandom);
                    end else if ($urandom_range(0, 15) == 0) begin
                        req[c] = 1'b0;
                    end
                end
            end else begin
                flush = 1'b0;
                req   = '0;
            end
            eval_model();
            seen_gnt = gnt;
            if (gnt !== e_gnt)      begin errors++; $display("FAIL random gnt got %b want %b", gnt, e_gnt); end
            if (rvalid !== e_rv)    begin errors++; $display("FAIL random rvalid got %b want %b", rvalid, e_rv); end
            if (busy !== e_busy)    begin errors++; $display("FAIL random busy got %b want %b", busy, e_busy); end
            if (mem_addr !== e_addr) begin errors++; $display("FAIL random mem_addr got %h want %h", mem_addr, e_addr); end
            checks += 4;
            if (e_rv != '0) begin
                checks++;
                if (rddata !== e_data) begin errors++; $display("FAIL random rddata got %h want %h", rddata, e_data); end
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h05] = 8'hA7;
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        flush    = 1'b0;
        m_ptr    = 0;
        m_last   = '0;
        test_reset();
        test_single();
        test_all_req();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
